// File: rtl/pdm_gen.sv
// ============================================================================
// Module   : pdm_gen
// Purpose  : Pulse-density generator, i_val ones per frame of 2**W cycles.
//            `define PDM_BURST_EN selects thermometer (single burst) mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_gen #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_out,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [W-1:0] C_LAST = {W{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] active_q, active_d;
  logic [W-1:0] fcnt_q, fcnt_d;
  logic         out_q, out_d;
  logic         done_q, done_d;
  logic [W-1:0] next_active;

`ifndef PDM_BURST_EN
  logic [W-1:0] acc_q, acc_d;
  logic [W:0]   sum;
`endif

  // A load in the same cycle as a frame start must win over the stale shadow.
  assign next_active = i_load ? i_val : shadow_q;

  always_comb begin
    state_d  = state_q;
    shadow_d = i_load ? i_val : shadow_q;
    active_d = active_q;
    fcnt_d   = fcnt_q;
    out_d    = 1'b0;
    done_d   = 1'b0;
`ifndef PDM_BURST_EN
    acc_d    = acc_q;
    sum      = {1'b0, acc_q} + {1'b0, active_q};
`endif
    case (state_q)
      IDLE: begin
        fcnt_d = '0;
`ifndef PDM_BURST_EN
        acc_d  = '0;
`endif
        if (i_en) begin
          state_d  = RUN;
          active_d = next_active;
        end
      end
      RUN: begin
        fcnt_d = fcnt_q + W'(1);
`ifdef PDM_BURST_EN
        out_d  = (fcnt_q < active_q);
`else
        acc_d  = sum[W-1:0];
        out_d  = sum[W];
`endif
        if (fcnt_q == C_LAST) begin
          done_d   = 1'b1;
          fcnt_d   = '0;
          active_d = next_active;
`ifndef PDM_BURST_EN
          acc_d    = '0;
`endif
          if (!i_en) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      fcnt_q   <= '0;
      out_q    <= 1'b0;
      done_q   <= 1'b0;
`ifndef PDM_BURST_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      fcnt_q   <= fcnt_d;
      out_q    <= out_d;
      done_q   <= done_d;
`ifndef PDM_BURST_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign o_out  = out_q;
  assign o_done = done_q;
  assign o_busy = (state_q == RUN);

endmodule

`default_nettype wire
